// File: rtl/challengeqsys_mem_pkg.sv
// Shared constants and helpers for the dual-port on-chip RAM: byte-lane
// width helper, byte-merge function and the legal read-latency range.
package challengeqsys_mem_pkg;

    localparam int LAT_MIN    = 1;
    localparam int LAT_MAX    = 2;
    // Widest data path the merge helper handles; callers zero-extend/truncate.
    localparam int MERGE_W    = 256;
    localparam int MERGE_BE_W = MERGE_W / 8;

    function automatic int be_w(input int data_w);
        return data_w / 8;
    endfunction

    function automatic logic [MERGE_W-1:0] byte_merge(
        input logic [MERGE_W-1:0]    old_word,
        input logic [MERGE_W-1:0]    new_word,
        input logic [MERGE_BE_W-1:0] be
    );
        logic [MERGE_W-1:0] res;
        res = old_word;
        for (int i = 0; i < MERGE_BE_W; i++) begin
            if (be[i]) begin
                res[i*8 +: 8] = new_word[i*8 +: 8];
            end else begin
                res[i*8 +: 8] = old_word[i*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/challengeqsys_mem_rd_pipe.sv
// Per-port read-return pipeline: READ_LATENCY stages of valid/data that
// freeze while stalled; out-of-range reads carry zero data.
module challengeqsys_mem_rd_pipe
    import challengeqsys_mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LAT    = LAT_MIN
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              stall,
    input  logic              rd_accept,
    input  logic              rd_oor,
    input  logic [DATA_W-1:0] rd_word,
    output logic [DATA_W-1:0] readdata,
    output logic              readdatavalid
);

    logic [LAT-1:0]    vld_r;
    logic [DATA_W-1:0] dat_r [LAT];

    // Shift valid/data one stage per non-stalled cycle; hold everything during a stall.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_r <= '0;
            for (int i = 0; i < LAT; i++) begin
                dat_r[i] <= '0;
            end
        end else if (!stall) begin
            vld_r[0] <= rd_accept;
            dat_r[0] <= (rd_accept && !rd_oor) ? rd_word : '0;
            for (int i = 1; i < LAT; i++) begin
                vld_r[i] <= vld_r[i-1];
                dat_r[i] <= dat_r[i-1];
            end
        end else begin
            vld_r <= vld_r;
        end
    end

    // A result waiting in the last stage is only presented on a non-stalled cycle.
    assign readdata      = dat_r[LAT-1];
    assign readdatavalid = vld_r[LAT-1] & ~stall;

endmodule

// File: rtl/challengeqsys_onchip_memory_dp.sv
// True-dual-port on-chip RAM with two Avalon-MM pipelined slaves (A = s1, B = s2),
// byte-enable writes, write-first cross-port reads and port-A-wins write collisions.
module challengeqsys_onchip_memory_dp
    import challengeqsys_mem_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 13,
    parameter int DEPTH        = 8192,
    parameter int READ_LATENCY = 1,
    parameter     INIT_FILE    = ""
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clken,
    input  logic                reset_req,
    input  logic                a_chipselect,
    input  logic                a_read,
    input  logic                a_write,
    input  logic [ADDR_W-1:0]   a_address,
    input  logic [DATA_W/8-1:0] a_byteenable,
    input  logic [DATA_W-1:0]   a_writedata,
    output logic                a_waitrequest,
    output logic [DATA_W-1:0]   a_readdata,
    output logic                a_readdatavalid,
    input  logic                b_chipselect,
    input  logic                b_read,
    input  logic                b_write,
    input  logic [ADDR_W-1:0]   b_address,
    input  logic [DATA_W/8-1:0] b_byteenable,
    input  logic [DATA_W-1:0]   b_writedata,
    output logic                b_waitrequest,
    output logic [DATA_W-1:0]   b_readdata,
    output logic                b_readdatavalid
);

    localparam int              BE_W    = be_w(DATA_W);
    localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    if (READ_LATENCY < LAT_MIN || READ_LATENCY > LAT_MAX || (DATA_W % 8) != 0 ||
        DATA_W > MERGE_W || DEPTH < 2 || DEPTH > (2 ** ADDR_W)) begin : g_param_err
        $error("challengeqsys_onchip_memory_dp: illegal parameter combination");
    end

    logic [DATA_W-1:0] mem [DEPTH];

    logic              stall_s;
    logic              a_inr_s, b_inr_s;
    logic              a_acc_s, b_acc_s;
    logic              a_we_s, b_we_s;
    logic              a_re_s, b_re_s;
    logic [IDX_W-1:0]  a_idx_s, b_idx_s;
    logic [DATA_W-1:0] a_word_s, b_word_s;

    assign stall_s       = ~clken | reset_req;
    assign a_waitrequest = stall_s;
    assign b_waitrequest = stall_s;
    assign a_idx_s       = a_address[IDX_W-1:0];
    assign b_idx_s       = b_address[IDX_W-1:0];

    // Request decode: accept, in-range check; read+write on one port counts as a write.
    always_comb begin
        a_inr_s = ({1'b0, a_address} < DEPTH_L);
        b_inr_s = ({1'b0, b_address} < DEPTH_L);
        a_acc_s = a_chipselect & (a_read | a_write) & ~stall_s;
        b_acc_s = b_chipselect & (b_read | b_write) & ~stall_s;
        a_we_s  = a_acc_s & a_write & a_inr_s;
        b_we_s  = b_acc_s & b_write & b_inr_s;
        a_re_s  = a_acc_s & a_read & ~a_write;
        b_re_s  = b_acc_s & b_read & ~b_write;
    end

    // Byte-lane writes; B is applied before A so A's lanes win on a shared address.
    always_ff @(posedge clk) begin
        for (int i = 0; i < BE_W; i++) begin
            if (b_we_s && b_byteenable[i]) begin
                mem[b_idx_s][i*8 +: 8] <= b_writedata[i*8 +: 8];
            end
            if (a_we_s && a_byteenable[i]) begin
                mem[a_idx_s][i*8 +: 8] <= a_writedata[i*8 +: 8];
            end
        end
    end

    // Write-first read words: merge the other port's same-cycle write into the stored word.
    always_comb begin
        a_word_s = mem[a_idx_s];
        b_word_s = mem[b_idx_s];
        if (b_we_s && (b_address == a_address)) begin
            a_word_s = DATA_W'(byte_merge(MERGE_W'(mem[a_idx_s]), MERGE_W'(b_writedata),
                                          MERGE_BE_W'(b_byteenable)));
        end else begin
            a_word_s = mem[a_idx_s];
        end
        if (a_we_s && (a_address == b_address)) begin
            b_word_s = DATA_W'(byte_merge(MERGE_W'(mem[b_idx_s]), MERGE_W'(a_writedata),
                                          MERGE_BE_W'(a_byteenable)));
        end else begin
            b_word_s = mem[b_idx_s];
        end
    end

    challengeqsys_mem_rd_pipe #(.DATA_W(DATA_W), .LAT(READ_LATENCY)) u_rd_pipe_a (
        .clk           (clk),
        .reset_n       (reset_n),
        .stall         (stall_s),
        .rd_accept     (a_re_s),
        .rd_oor        (~a_inr_s),
        .rd_word       (a_word_s),
        .readdata      (a_readdata),
        .readdatavalid (a_readdatavalid)
    );

    challengeqsys_mem_rd_pipe #(.DATA_W(DATA_W), .LAT(READ_LATENCY)) u_rd_pipe_b (
        .clk           (clk),
        .reset_n       (reset_n),
        .stall         (stall_s),
        .rd_accept     (b_re_s),
        .rd_oor        (~b_inr_s),
        .rd_word       (b_word_s),
        .readdata      (b_readdata),
        .readdatavalid (b_readdatavalid)
    );

endmodule

// File: tb/tb_challengeqsys_onchip_memory_dp.sv
// Bench: two RAM instances (32-bit latency 1, 64-bit latency 2, DEPTH 6000) share stimulus;
// the 64-bit copy sees {~wd, wd} so its upper half must read back as the complement.
module tb_challengeqsys_onchip_memory_dp;

    localparam int DEPTH_T = 6000;

    logic        clk = 1'b0;
    logic        reset_n, clken, reset_req;
    logic        a_cs, a_rd, a_wr, b_cs, b_rd, b_wr;
    logic [12:0] a_addr, b_addr;
    logic [3:0]  a_be, b_be;
    logic [31:0] a_wd, b_wd;

    logic        d1_a_wait, d1_b_wait, d1_a_rdv, d1_b_rdv;
    logic [31:0] d1_a_rdata, d1_b_rdata;
    logic        d2_a_wait, d2_b_wait, d2_a_rdv, d2_b_rdv;
    logic [63:0] d2_a_rdata, d2_b_rdata;

    always #5 clk = ~clk;

    challengeqsys_onchip_memory_dp #(.DATA_W(32), .ADDR_W(13), .DEPTH(DEPTH_T), .READ_LATENCY(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .clken(clken), .reset_req(reset_req),
        .a_chipselect(a_cs), .a_read(a_rd), .a_write(a_wr), .a_address(a_addr),
        .a_byteenable(a_be), .a_writedata(a_wd), .a_waitrequest(d1_a_wait),
        .a_readdata(d1_a_rdata), .a_readdatavalid(d1_a_rdv),
        .b_chipselect(b_cs), .b_read(b_rd), .b_write(b_wr), .b_address(b_addr),
        .b_byteenable(b_be), .b_writedata(b_wd), .b_waitrequest(d1_b_wait),
        .b_readdata(d1_b_rdata), .b_readdatavalid(d1_b_rdv)
    );

    challengeqsys_onchip_memory_dp #(.DATA_W(64), .ADDR_W(13), .DEPTH(DEPTH_T), .READ_LATENCY(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .clken(clken), .reset_req(reset_req),
        .a_chipselect(a_cs), .a_read(a_rd), .a_write(a_wr), .a_address(a_addr),
        .a_byteenable({a_be, a_be}), .a_writedata({~a_wd, a_wd}), .a_waitrequest(d2_a_wait),
        .a_readdata(d2_a_rdata), .a_readdatavalid(d2_a_rdv),
        .b_chipselect(b_cs), .b_read(b_rd), .b_write(b_wr), .b_address(b_addr),
        .b_byteenable({b_be, b_be}), .b_writedata({~b_wd, b_wd}), .b_waitrequest(d2_b_wait),
        .b_readdata(d2_b_rdata), .b_readdatavalid(d2_b_rdv)
    );

    typedef struct {
        logic [63:0] data;
        int          cyc;
        int          stl;
    } sb_t;

    typedef struct {
        logic        a_rd, a_wr;
        logic [12:0] a_addr;
        logic [3:0]  a_be;
        logic [31:0] a_wd, a_exp;
        logic        b_rd, b_wr;
        logic [12:0] b_addr;
        logic [3:0]  b_be;
        logic [31:0] b_wd, b_exp;
    } vec_t;

    sb_t  q0[$], q1[$], q2[$], q3[$];
    vec_t vt[16];
    int   total = 0, bad = 0, cyc = 0, stall_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Queues 0/1: dut1 ports A/B; queues 2/3: dut2 ports A/B.
    task automatic push_rd(input int port, input logic [31:0] e, input logic [12:0] addr);
        sb_t s;
        logic oor;
        oor   = (int'(addr) >= DEPTH_T);
        s.cyc = cyc;
        s.stl = stall_cnt;
        s.data = oor ? 64'h0 : {32'h0, e};
        if (port == 0) q0.push_back(s); else q1.push_back(s);
        s.data = oor ? 64'h0 : {~e, e};
        if (port == 0) q2.push_back(s); else q3.push_back(s);
    endtask

    task automatic mon(input int k, input logic v, input logic [63:0] d, input logic stl);
        sb_t  e;
        logic found;
        int   lat;
        found = 1'b0;
        lat   = (k < 2) ? 1 : 2;
        if (v) begin
            chk($sformatf("pulse_in_stall_q%0d", k), {63'h0, stl}, 64'h0);
            case (k)
                0: if (q0.size() > 0) begin e = q0.pop_front(); found = 1'b1; end
                1: if (q1.size() > 0) begin e = q1.pop_front(); found = 1'b1; end
                2: if (q2.size() > 0) begin e = q2.pop_front(); found = 1'b1; end
                3: if (q3.size() > 0) begin e = q3.pop_front(); found = 1'b1; end
                default: found = 1'b0;
            endcase
            if (!found) begin
                chk($sformatf("unexpected_pulse_q%0d", k), 64'h1, 64'h0);
            end else begin
                chk($sformatf("rdata_q%0d", k), d, e.data);
                chk($sformatf("latency_q%0d", k), 64'(cyc), 64'(e.cyc + lat + (stall_cnt - e.stl)));
            end
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            mon(0, d1_a_rdv, {32'h0, d1_a_rdata}, d1_a_wait);
            mon(1, d1_b_rdv, {32'h0, d1_b_rdata}, d1_b_wait);
            mon(2, d2_a_rdv, d2_a_rdata, d2_a_wait);
            mon(3, d2_b_rdv, d2_b_rdata, d2_b_wait);
            if (d1_a_wait) stall_cnt++;
        end
    end

    task automatic set_a(input logic rd, input logic wr, input logic [12:0] ad,
                         input logic [3:0] be, input logic [31:0] wd);
        a_cs = rd | wr; a_rd = rd; a_wr = wr; a_addr = ad; a_be = be; a_wd = wd;
    endtask

    task automatic set_b(input logic rd, input logic wr, input logic [12:0] ad,
                         input logic [3:0] be, input logic [31:0] wd);
        b_cs = rd | wr; b_rd = rd; b_wr = wr; b_addr = ad; b_be = be; b_wd = wd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //          a_rd  a_wr  a_addr     a_be  a_wd          a_exp         b_rd  b_wr  b_addr     b_be  b_wd          b_exp
        vt[0]  = '{1'b0, 1'b1, 13'd5,    4'hF, 32'hAABBCCDD, 32'h0,        1'b0, 1'b0, 13'd0,    4'h0, 32'h0,        32'h0};
        vt[1]  = '{1'b0, 1'b1, 13'd5,    4'h5, 32'h11223344, 32'h0,        1'b0, 1'b0, 13'd0,    4'h0, 32'h0,        32'h0};
        vt[2]  = '{1'b0, 1'b0, 13'd0,    4'h0, 32'h0,        32'h0,        1'b1, 1'b0, 13'd5,    4'h0, 32'h0,        32'hAA22CC44};
        vt[3]  = '{1'b0, 1'b1, 13'd7,    4'hF, 32'h11111111, 32'h0,        1'b0, 1'b1, 13'd7,    4'hF, 32'h22222222, 32'h0};
        vt[4]  = '{1'b1, 1'b0, 13'd7,    4'h0, 32'h0,        32'h11111111, 1'b0, 1'b0, 13'd0,    4'h0, 32'h0,        32'h0};
        vt[5]  = '{1'b0, 1'b1, 13'd7,    4'h3, 32'h11111111, 32'h0,        1'b0, 1'b1, 13'd7,    4'hC, 32'h22222222, 32'h0};
        vt[6]  = '{1'b1, 1'b0, 13'd7,    4'h0, 32'h0,        32'h22221111, 1'b1, 1'b0, 13'd7,    4'h0, 32'h0,        32'h22221111};
        vt[7]  = '{1'b0, 1'b1, 13'd9,    4'hF, 32'h00000000, 32'h0,        1'b0, 1'b0, 13'd0,    4'h0, 32'h0,        32'h0};
        vt[8]  = '{1'b0, 1'b1, 13'd9,    4'h8, 32'hDEADBEEF, 32'h0,        1'b1, 1'b0, 13'd9,    4'h0, 32'h0,        32'hDE000000};
        vt[9]  = '{1'b1, 1'b0, 13'd9,    4'h0, 32'h0,        32'hDE000000, 1'b0, 1'b0, 13'd0,    4'h0, 32'h0,        32'h0};
        vt[10] = '{1'b0, 1'b0, 13'd0,    4'h0, 32'h0,        32'h0,        1'b1, 1'b1, 13'd9,    4'h1, 32'h00000055, 32'h0};
        vt[11] = '{1'b1, 1'b0, 13'd9,    4'h0, 32'h0,        32'hDE000055, 1'b0, 1'b0, 13'd0,    4'h0, 32'h0,        32'h0};
        vt[12] = '{1'b1, 1'b0, 13'd6000, 4'h0, 32'h0,        32'h0,        1'b0, 1'b1, 13'd6001, 4'hF, 32'hFFFFFFFF, 32'h0};
        vt[13] = '{1'b0, 1'b1, 13'd5999, 4'hF, 32'hCAFEF00D, 32'h0,        1'b1, 1'b0, 13'd6001, 4'h0, 32'h0,        32'h0};
        vt[14] = '{1'b0, 1'b0, 13'd0,    4'h0, 32'h0,        32'h0,        1'b1, 1'b0, 13'd5999, 4'h0, 32'h0,        32'hCAFEF00D};
        vt[15] = '{1'b1, 1'b0, 13'd5,    4'h0, 32'h0,        32'hAA22CC44, 1'b1, 1'b0, 13'd7,    4'h0, 32'h0,        32'h22221111};

        reset_n = 1'b0; clken = 1'b1; reset_req = 1'b0;
        set_a(1'b0, 1'b0, 13'd0, 4'h0, 32'h0);
        set_b(1'b0, 1'b0, 13'd0, 4'h0, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_d1_a_rdata", {32'h0, d1_a_rdata}, 64'h0);
        chk("rst_d1_b_rdv",   {63'h0, d1_b_rdv},   64'h0);
        chk("rst_d2_a_rdata", d2_a_rdata,          64'h0);
        chk("rst_d2_b_rdv",   {63'h0, d2_b_rdv},   64'h0);
        chk("rst_waitreq",    {63'h0, d1_a_wait},  64'h0);
        step();
        reset_n = 1'b1;
        step();

        // Read in flight when reset arrives must never return.
        set_a(1'b1, 1'b0, 13'h10, 4'h0, 32'h0);
        step();
        reset_n = 1'b0;
        set_a(1'b0, 1'b0, 13'd0, 4'h0, 32'h0);
        repeat (2) begin
            @(negedge clk);
            chk("midrst_d1_rdv", {63'h0, d1_a_rdv}, 64'h0);
            chk("midrst_d2_rdv", {63'h0, d2_a_rdv}, 64'h0);
        end
        step();
        reset_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("postrst_d1_rdv", {63'h0, d1_a_rdv}, 64'h0);
            chk("postrst_d2_rdv", {63'h0, d2_a_rdv}, 64'h0);
        end
        chk("postrst_d1_rdata", {32'h0, d1_a_rdata}, 64'h0);
        chk("postrst_d2_rdata", d2_a_rdata,          64'h0);
        step();

        for (int i = 0; i < 16; i++) begin
            set_a(vt[i].a_rd, vt[i].a_wr, vt[i].a_addr, vt[i].a_be, vt[i].a_wd);
            set_b(vt[i].b_rd, vt[i].b_wr, vt[i].b_addr, vt[i].b_be, vt[i].b_wd);
            if (vt[i].a_rd && !vt[i].a_wr) push_rd(0, vt[i].a_exp, vt[i].a_addr);
            if (vt[i].b_rd && !vt[i].b_wr) push_rd(1, vt[i].b_exp, vt[i].b_addr);
            step();
        end
        set_a(1'b0, 1'b0, 13'd0, 4'h0, 32'h0);
        set_b(1'b0, 1'b0, 13'd0, 4'h0, 32'h0);
        step();

        // Stall sequence: preload 0..2, blocked write under reset_req, then reads with a 3-cycle clken gap.
        set_a(1'b0, 1'b1, 13'd0, 4'hF, 32'h01010101); step();
        set_a(1'b0, 1'b1, 13'd1, 4'hF, 32'h02020202); step();
        set_a(1'b0, 1'b1, 13'd2, 4'hF, 32'h03030303); step();
        reset_req = 1'b1;
        set_a(1'b0, 1'b1, 13'd0, 4'hF, 32'hFFFFFFFF);
        @(negedge clk);
        chk("rreq_d1_waitreq", {63'h0, d1_a_wait}, 64'h1);
        chk("rreq_d2_waitreq", {63'h0, d2_b_wait}, 64'h1);
        step();
        reset_req = 1'b0;
        set_a(1'b1, 1'b0, 13'd0, 4'h0, 32'h0); push_rd(0, 32'h01010101, 13'd0); step();
        set_a(1'b1, 1'b0, 13'd1, 4'h0, 32'h0); push_rd(0, 32'h02020202, 13'd1); step();
        clken = 1'b0;
        set_a(1'b1, 1'b0, 13'd2, 4'h0, 32'h0);
        repeat (3) begin
            @(negedge clk);
            chk("stall_d1_rdv",  {63'h0, d1_a_rdv},  64'h0);
            chk("stall_d2_rdv",  {63'h0, d2_a_rdv},  64'h0);
            chk("stall_waitreq", {63'h0, d1_b_wait}, 64'h1);
            step();
        end
        clken = 1'b1;
        push_rd(0, 32'h03030303, 13'd2);
        step();
        set_a(1'b0, 1'b0, 13'd0, 4'h0, 32'h0);

        for (int i = 0; i < 20 && (q0.size() + q1.size() + q2.size() + q3.size()) > 0; i++) begin
            step();
        end
        chk("scoreboard_drained", 64'(q0.size() + q1.size() + q2.size() + q3.size()), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
